// File: rtl/byte_lane_packer_pkg.sv
// Shared types for the byte lane packer and the downstream 16-bit holding register.
package byte_lane_packer_pkg;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  byte_en;
    } word_t;

    // Byte in the selected lane; the other lane's data and enable are zero.
    function automatic word_t place_byte(input logic [7:0] b, input logic lane);
        word_t w;
        w = '0;
        if (lane == LANE_HI) begin
            w.data[15:8] = b;
            w.byte_en[1] = 1'b1;
        end else begin
            w.data[7:0]  = b;
            w.byte_en[0] = 1'b1;
        end
        return w;
    endfunction

endpackage

// File: rtl/byte_lane_packer_lane_out_reg.sv
// Single-entry valid/ready output register: load on emit, hold while stalled,
// drop valid once the word is taken.
module lane_out_reg
    import byte_lane_packer_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_load,
    input  word_t i_word,
    input  logic  i_ready,
    output logic  o_valid,
    output word_t o_word
);

    logic  r_valid;
    word_t r_word;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_word  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_word  <= i_word;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_word  = r_word;

endmodule

// File: rtl/byte_lane_packer.sv
// Merges lane-tagged bytes into byte-enabled 16-bit words, emitting on a full
// word, lane collision, last marker or idle timeout.
module byte_lane_packer
    import byte_lane_packer_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_byte,
    input  logic        in_lane,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [1:0]  out_byte_en,
    output logic        acc_busy
);

    localparam int CNT_W = (TIMEOUT <= 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    word_t            r_acc;
    logic             r_flush_pending;
    logic [CNT_W-1:0] r_cnt;

    word_t            w_acc_nxt;
    logic             w_flush_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_emit;
    word_t            w_emit_word;
    word_t            w_new;
    word_t            w_merged;
    logic             w_slot_free;
    logic             w_accept;
    word_t            w_out_word;

    assign w_slot_free = !out_valid || out_ready;
    assign in_ready    = rst_n && w_slot_free && !r_flush_pending;
    assign w_accept    = in_valid && in_ready;
    assign w_new       = place_byte(in_byte, in_lane);
    assign w_merged    = r_acc | w_new;

    always_comb begin
        w_acc_nxt   = r_acc;
        w_flush_nxt = r_flush_pending;
        w_cnt_nxt   = r_cnt;
        w_emit      = 1'b0;
        w_emit_word = r_acc;
        if (w_accept) begin
            w_cnt_nxt = '0;
            if (r_acc.byte_en[in_lane]) begin
                w_emit      = 1'b1;
                w_emit_word = r_acc;
                w_acc_nxt   = w_new;
                w_flush_nxt = in_last;
            end else if ((w_merged.byte_en == 2'b11) || in_last) begin
                w_emit      = 1'b1;
                w_emit_word = w_merged;
                w_acc_nxt   = '0;
            end else begin
                w_acc_nxt = w_merged;
            end
        end else if (r_flush_pending) begin
            if (w_slot_free) begin
                w_emit      = 1'b1;
                w_acc_nxt   = '0;
                w_flush_nxt = 1'b0;
            end
        end else if ((r_acc.byte_en != 2'b00) && (TIMEOUT > 0)) begin
            // Saturate at the limit so a stalled output still flushes later.
            if (r_cnt == TO_CNT) begin
                if (w_slot_free) begin
                    w_emit    = 1'b1;
                    w_acc_nxt = '0;
                    w_cnt_nxt = '0;
                end
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end else begin
            w_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc           <= '0;
            r_flush_pending <= 1'b0;
            r_cnt           <= '0;
        end else begin
            r_acc           <= w_acc_nxt;
            r_flush_pending <= w_flush_nxt;
            r_cnt           <= w_cnt_nxt;
        end
    end

    lane_out_reg u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_emit),
        .i_word  (w_emit_word),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_word  (w_out_word)
    );

    assign out_data    = w_out_word.data;
    assign out_byte_en = w_out_word.byte_en;
    assign acc_busy    = (r_acc.byte_en != 2'b00) || r_flush_pending;

endmodule

// File: tb/tb_byte_lane_packer.sv
// Directed bench for byte_lane_packer with a short idle timeout.
module tb_byte_lane_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic        in_lane;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_byte_en;
    logic        acc_busy;

    int nvec = 0;
    int nerr = 0;

    byte_lane_packer #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_byte     (in_byte),
        .in_lane     (in_lane),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_byte_en (out_byte_en),
        .acc_busy    (acc_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic lane, input logic last);
        in_valid = 1'b1;
        in_byte  = b;
        in_lane  = lane;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_byte = '0; in_lane = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        tick(); tick();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        nvec++; if (out_data !== 16'h0000) begin nerr++; $display("FAIL reset_out_data got %h want 0000", out_data); end
        nvec++; if (out_byte_en !== 2'b00) begin nerr++; $display("FAIL reset_byte_en got %b want 00", out_byte_en); end
        nvec++; if (acc_busy !== 1'b0) begin nerr++; $display("FAIL reset_acc_busy got %b want 0", acc_busy); end
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        rst_n = 1'b1;
        tick();
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_full_word();
        out_ready = 1'b1;
        send(8'hAA, 1'b0, 1'b0);
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL full_half_valid got %b want 0", out_valid); end
        nvec++; if (acc_busy !== 1'b1) begin nerr++; $display("FAIL full_half_busy got %b want 1", acc_busy); end
        send(8'h55, 1'b1, 1'b0);
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL full_valid got %b want 1", out_valid); end
        nvec++; if (out_data !== 16'h55AA) begin nerr++; $display("FAIL full_data got %h want 55aa", out_data); end
        nvec++; if (out_byte_en !== 2'b11) begin nerr++; $display("FAIL full_en got %b want 11", out_byte_en); end
        nvec++; if (acc_busy !== 1'b0) begin nerr++; $display("FAIL full_busy got %b want 0", acc_busy); end
        tick();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL full_consumed got %b want 0", out_valid); end
    endtask

    task automatic test_last();
        send(8'h3C, 1'b1, 1'b1);
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL last_valid got %b want 1", out_valid); end
        nvec++; if (out_data !== 16'h3C00) begin nerr++; $display("FAIL last_data got %h want 3c00", out_data); end
        nvec++; if (out_byte_en !== 2'b10) begin nerr++; $display("FAIL last_en got %b want 10", out_byte_en); end
        tick();
    endtask

    task automatic test_collision_last();
        send(8'h11, 1'b0, 1'b0);
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL coll_first_valid got %b want 0", out_valid); end
        send(8'h22, 1'b0, 1'b1);
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL coll_valid got %b want 1", out_valid); end
        nvec++; if (out_data !== 16'h0011) begin nerr++; $display("FAIL coll_data got %h want 0011", out_data); end
        nvec++; if (out_byte_en !== 2'b01) begin nerr++; $display("FAIL coll_en got %b want 01", out_byte_en); end
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL coll_in_ready got %b want 0", in_ready); end
        nvec++; if (acc_busy !== 1'b1) begin nerr++; $display("FAIL coll_busy got %b want 1", acc_busy); end
        tick();
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL flush_valid got %b want 1", out_valid); end
        nvec++; if (out_data !== 16'h0022) begin nerr++; $display("FAIL flush_data got %h want 0022", out_data); end
        nvec++; if (out_byte_en !== 2'b01) begin nerr++; $display("FAIL flush_en got %b want 01", out_byte_en); end
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
        nvec++; if (acc_busy !== 1'b0) begin nerr++; $display("FAIL flush_busy got %b want 0", acc_busy); end
        tick();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL flush_consumed got %b want 0", out_valid); end
    endtask

    task automatic test_timeout();
        send(8'h7E, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL tmo_early idle=%0d got %b want 0", i, out_valid); end
        end
        tick();
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL tmo_valid got %b want 1", out_valid); end
        nvec++; if (out_data !== 16'h007E) begin nerr++; $display("FAIL tmo_data got %h want 007e", out_data); end
        nvec++; if (out_byte_en !== 2'b01) begin nerr++; $display("FAIL tmo_en got %b want 01", out_byte_en); end
        nvec++; if (acc_busy !== 1'b0) begin nerr++; $display("FAIL tmo_busy got %b want 0", acc_busy); end
        tick();
        // Byte arriving one cycle before expiry collides and restarts the count.
        send(8'h7E, 1'b0, 1'b0);
        tick(); tick(); tick();
        send(8'h81, 1'b0, 1'b0);
        nvec++; if (out_data !== 16'h007E || out_valid !== 1'b1) begin nerr++; $display("FAIL restart_coll got %b/%h want 1/007e", out_valid, out_data); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL restart_early idle=%0d got %b want 0", i, out_valid); end
        end
        tick();
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL restart_valid got %b want 1", out_valid); end
        nvec++; if (out_data !== 16'h0081) begin nerr++; $display("FAIL restart_data got %h want 0081", out_data); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(8'hA1, 1'b0, 1'b0);
        send(8'hB2, 1'b1, 1'b0);
        nvec++; if (out_valid !== 1'b1 || out_data !== 16'hB2A1) begin nerr++; $display("FAIL bp_word got %b/%h want 1/b2a1", out_valid, out_data); end
        in_valid = 1'b1; in_byte = 8'hC3; in_lane = 1'b0; in_last = 1'b1;
        #1;
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        for (int i = 0; i < 6; i++) begin
            tick();
            nvec++; if (out_data !== 16'hB2A1 || out_valid !== 1'b1) begin nerr++; $display("FAIL bp_hold cyc=%0d got %b/%h want 1/b2a1", i, out_valid, out_data); end
        end
        out_ready = 1'b1;
        #1;
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL bp_next_valid got %b want 1", out_valid); end
        nvec++; if (out_data !== 16'h00C3) begin nerr++; $display("FAIL bp_next_data got %h want 00c3", out_data); end
        nvec++; if (out_byte_en !== 2'b01) begin nerr++; $display("FAIL bp_next_en got %b want 01", out_byte_en); end
        tick();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL bp_drained got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send(8'h99, 1'b0, 1'b0);
        nvec++; if (acc_busy !== 1'b1) begin nerr++; $display("FAIL mid_busy_before got %b want 1", acc_busy); end
        rst_n = 1'b0;
        tick();
        nvec++; if (acc_busy !== 1'b0) begin nerr++; $display("FAIL mid_busy got %b want 0", acc_busy); end
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL mid_valid got %b want 0", out_valid); end
        rst_n = 1'b1;
        send(8'h01, 1'b1, 1'b1);
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL mid_after_valid got %b want 1", out_valid); end
        nvec++; if (out_data !== 16'h0100) begin nerr++; $display("FAIL mid_after_data got %h want 0100", out_data); end
        nvec++; if (out_byte_en !== 2'b10) begin nerr++; $display("FAIL mid_after_en got %b want 10", out_byte_en); end
        tick();
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_last();
        test_collision_last();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
